// File: rtl/instruction_fetch.sv
// instruction_fetch: issues ROM reads from the PC and queues fetched
// words in a 2-entry FIFO for decode; redirects flush and refetch.
module instruction_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pc,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic        rom_en,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_entry_t;

  fetch_entry_t q0;
  fetch_entry_t q1;
  fetch_entry_t new_e;
  logic [1:0]   count;
  logic         inflight;
  logic         squash;
  logic [15:0]  inflight_addr;
  logic         pop;
  logic         push;
  logic [2:0]   occ;
  logic [2:0]   limit;

  assign instr_valid = (count != 2'd0);
  assign instr       = q0.instr;
  assign instr_pc    = q0.pc;
  assign rom_addr    = pc;

  assign pop   = instr_valid & instr_ready & ~redirect;
  assign push  = inflight & ~squash & ~redirect;
  assign occ   = {1'b0, count} + {2'b00, inflight};
  assign limit = 3'd2 + {2'b00, pop};
  assign new_e = '{instr: rom_data, pc: inflight_addr};

  assign rom_en    = reset_n & ~redirect & (occ < limit);
  assign pc_inc    = rom_en;
  assign pc_load   = reset_n & redirect;
  assign pc_target = pc_load ? redirect_addr : 16'h0000;

  // Track the single outstanding ROM read and whether it was flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight      <= 1'b0;
      squash        <= 1'b0;
      inflight_addr <= 16'h0000;
    end else begin
      inflight <= rom_en;
      squash   <= redirect & inflight;
      if (rom_en) inflight_addr <= rom_addr;
    end
  end

  // Two-entry queue: q0 is the head, q1 the second slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      q0    <= '0;
      q1    <= '0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            q0 <= q1;
            q1 <= new_e;
          end else begin
            q0 <= new_e;
          end
        end
        2'b10: begin
          if (count == 2'd0) q0 <= new_e;
          else q1 <= new_e;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) q0 <= q1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: drives instruction_fetch with a PC register and
// a 1-cycle ROM, checking the accepted stream against address order.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pc;
  logic        pc_inc;
  logic        pc_load;
  logic [15:0] pc_target;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int total = 0;
  int passed = 0;

  instruction_fetch dut (
    .clk(clk), .reset_n(reset_n), .pc(pc),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= 16'h0000;
    else if (pc_load) pc <= pc_target;
    else if (pc_inc) pc <= pc + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(rom_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    redirect = 1'b1;
    redirect_addr = 16'hBEEF;
    instr_ready = 1'b1;
    tick();
    #1;
    total++;
    if ({rom_en, pc_inc, pc_load, instr_valid} !== 4'b0000)
      $display("FAIL reset_ctl: got %b want 0000",
               {rom_en, pc_inc, pc_load, instr_valid});
    else passed++;
    total++;
    if (pc_target !== 16'h0000)
      $display("FAIL reset_target: got %h want 0000", pc_target);
    else passed++;
    total++;
    if ({instr, instr_pc} !== 32'h0)
      $display("FAIL reset_head: got %h want 0", {instr, instr_pc});
    else passed++;
    redirect = 1'b0;
  endtask

  task automatic test_stream;
    instr_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i == 0) begin
        total++;
        if (rom_en !== 1'b1)
          $display("FAIL stream_first_issue: got %b want 1", rom_en);
        else passed++;
      end
      total++;
      if (instr_valid !== (i >= 2))
        $display("FAIL stream_valid c%0d: got %b want %b",
                 i, instr_valid, (i >= 2));
      else passed++;
      if (i >= 2) begin
        total++;
        if (instr_pc !== 16'(i - 2) || instr !== rom_word(16'(i - 2)))
          $display("FAIL stream_data c%0d: got %h/%h want %h/%h", i,
                   instr_pc, instr, 16'(i - 2), rom_word(16'(i - 2)));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_stall;
    logic [15:0] exp;
    instr_ready = 1'b1;
    apply_reset();
    tick();
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (!instr_valid || instr_pc !== 16'h0000 || instr !== 16'h1000)
        $display("FAIL stall_head s%0d: got %b %h/%h want 1 0000/1000",
                 i, instr_valid, instr_pc, instr);
      else passed++;
      if (i == 4) begin
        total++;
        if (rom_en !== 1'b0 || pc_inc !== 1'b0 || pc !== 16'h0002)
          $display("FAIL stall_hold: got en=%b inc=%b pc=%h want 0 0 0002",
                   rom_en, pc_inc, pc);
        else passed++;
      end
      tick();
    end
    instr_ready = 1'b1;
    exp = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (instr_valid) begin
        total++;
        if (instr_pc !== exp || instr !== rom_word(exp))
          $display("FAIL stall_resume: got %h/%h want %h/%h",
                   instr_pc, instr, exp, rom_word(exp));
        else passed++;
        exp = exp + 16'd1;
      end
      tick();
    end
    total++;
    if (exp !== 16'd8)
      $display("FAIL stall_rate: got %0d pops want 8", exp);
    else passed++;
  endtask

  task automatic test_redirect_inflight;
    instr_ready = 1'b1;
    apply_reset();
    tick();
    redirect = 1'b1;
    redirect_addr = 16'h0040;
    #1;
    total++;
    if (pc_load !== 1'b1 || pc_target !== 16'h0040 ||
        rom_en !== 1'b0 || pc_inc !== 1'b0)
      $display("FAIL redir_ctl: got %b %h %b %b want 1 0040 0 0",
               pc_load, pc_target, rom_en, pc_inc);
    else passed++;
    tick();
    redirect = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      total++;
      if (instr_valid !== (j >= 2))
        $display("FAIL redir_valid j%0d: got %b want %b",
                 j, instr_valid, (j >= 2));
      else passed++;
      if (j >= 2) begin
        total++;
        if (instr_pc !== 16'(64 + j - 2) || instr !== rom_word(16'(64 + j - 2)))
          $display("FAIL redir_data j%0d: got %h/%h want %h/%h", j,
                   instr_pc, instr, 16'(64 + j - 2), rom_word(16'(64 + j - 2)));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_redirect_full;
    instr_ready = 1'b1;
    apply_reset();
    tick();
    tick();
    instr_ready = 1'b0;
    tick();
    #1;
    total++;
    if (rom_en !== 1'b0 || !instr_valid)
      $display("FAIL full_stall: got en=%b v=%b want 0 1", rom_en, instr_valid);
    else passed++;
    tick();
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 16'h0080;
    #1;
    total++;
    if (pc_load !== 1'b1 || rom_en !== 1'b0)
      $display("FAIL full_redir: got load=%b en=%b want 1 0", pc_load, rom_en);
    else passed++;
    tick();
    redirect = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      total++;
      if (instr_valid !== (j >= 2))
        $display("FAIL full_valid j%0d: got %b want %b",
                 j, instr_valid, (j >= 2));
      else passed++;
      if (j == 2) begin
        total++;
        if (instr_pc !== 16'h0080 || instr !== rom_word(16'h0080))
          $display("FAIL full_data: got %h/%h want 0080/%h",
                   instr_pc, instr, rom_word(16'h0080));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    instr_ready = 1'b1;
    apply_reset();
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_addr = 16'h0100;
    tick();
    redirect_addr = 16'h0200;
    tick();
    redirect = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      total++;
      if (instr_valid !== (j >= 2))
        $display("FAIL b2b_valid j%0d: got %b want %b",
                 j, instr_valid, (j >= 2));
      else passed++;
      if (j >= 2) begin
        total++;
        if (instr_pc !== 16'(512 + j - 2))
          $display("FAIL b2b_pc j%0d: got %h want %h",
                   j, instr_pc, 16'(512 + j - 2));
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_wrap;
    logic [15:0] exp;
    instr_ready = 1'b1;
    apply_reset();
    redirect = 1'b1;
    redirect_addr = 16'hFFFE;
    tick();
    redirect = 1'b0;
    exp = 16'hFFFE;
    for (int j = 0; j < 6; j++) begin
      #1;
      if (instr_valid) begin
        total++;
        if (instr_pc !== exp || instr !== rom_word(exp))
          $display("FAIL wrap_data: got %h/%h want %h/%h",
                   instr_pc, instr, exp, rom_word(exp));
        else passed++;
        exp = exp + 16'd1;
      end
      tick();
    end
    total++;
    if (exp !== 16'h0002)
      $display("FAIL wrap_count: got next %h want 0002", exp);
    else passed++;
  endtask

  task automatic test_reset_mid;
    instr_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0;
    #1;
    total++;
    if ({rom_en, pc_inc, pc_load, instr_valid} !== 4'b0000 ||
        {pc_target, instr, instr_pc} !== 48'h0)
      $display("FAIL midrst_out: got %b %h %h %h want all 0",
               {rom_en, pc_inc, pc_load, instr_valid},
               pc_target, instr, instr_pc);
    else passed++;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    total++;
    if (rom_en !== 1'b1 || rom_addr !== 16'h0000)
      $display("FAIL midrst_issue: got %b %h want 1 0000", rom_en, rom_addr);
    else passed++;
    tick();
    for (int j = 1; j < 4; j++) begin
      #1;
      total++;
      if (instr_valid !== (j >= 2))
        $display("FAIL midrst_valid j%0d: got %b want %b",
                 j, instr_valid, (j >= 2));
      else passed++;
      if (j == 2) begin
        total++;
        if (instr_pc !== 16'h0000 || instr !== 16'h1000)
          $display("FAIL midrst_data: got %h/%h want 0000/1000",
                   instr_pc, instr);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_random;
    logic [15:0] exp;
    int accepted;
    instr_ready = 1'b1;
    apply_reset();
    exp = 16'h0000;
    accepted = 0;
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom % 4) != 0;
      redirect = ($urandom % 12) == 0;
      redirect_addr = 16'($urandom);
      #1;
      total++;
      if (pc_inc !== rom_en)
        $display("FAIL rnd_inc c%0d: got %b want %b", i, pc_inc, rom_en);
      else passed++;
      if (redirect) begin
        total++;
        if (pc_load !== 1'b1 || rom_en !== 1'b0 || pc_target !== redirect_addr)
          $display("FAIL rnd_redir c%0d: got %b %b %h want 1 0 %h",
                   i, pc_load, rom_en, pc_target, redirect_addr);
        else passed++;
        exp = redirect_addr;
      end else if (instr_valid && instr_ready) begin
        total++;
        if (instr_pc !== exp || instr !== rom_word(exp))
          $display("FAIL rnd_data c%0d: got %h/%h want %h/%h",
                   i, instr_pc, instr, exp, rom_word(exp));
        else passed++;
        exp = exp + 16'd1;
        accepted++;
      end
      tick();
    end
    redirect = 1'b0;
    total++;
    if (accepted < 50)
      $display("FAIL rnd_progress: got %0d accepts want >= 50", accepted);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_full();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
